vot3_sesiune: RTL and testbench
===============================

Name: vot3_sesiune

Overview:
- Ballot-collection controller for a three-voter session.
- Opens a voting window on `start`, latches each voter's first YES/NO press, and closes when all three have voted or a timeout expires.
- Missing votes are forced to NO, and the registered 2-of-3 majority is published with a one-cycle valid pulse.
- Sits upstream of the majority logic: it produces the three settled votes plus the final decision and status.

Parameters:
- TIMEOUT_CYCLES, 16, number of clock cycles the window stays open (allowed range 2..2^CNT_W).
- CNT_W, 5, width of the internal window timer.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous reset, active low
- start  input  1  opens a session; sampled only in IDLE
- btn_da  input  3  per-voter YES press, bit i = voter i, level sampled each cycle
- btn_nu  input  3  per-voter NO press, bit i = voter i
- busy  output  1  high in OPEN and DECIDE
- voted  output  3  bit i high once voter i's vote is latched in the current session
- vote_val  output  3  latched vote of voter i (1 = YES, 0 = NO); 0 for voters who have not voted
- result  output  1  registered majority of vote_val; held until the next start is accepted
- result_valid  output  1  one-cycle pulse when result is updated
- timeout_flag  output  1  high if the last session closed by timeout; held until the next start is accepted

Behaviour:
- Reset: while rst_n=0 at a rising edge, the following are cleared.
  - state <= IDLE.
  - busy, voted, vote_val, result, result_valid, timeout_flag, timer all <= 0.
- Reset has priority over every other event, including mid-session; a session aborted by reset produces no result_valid.
- States are IDLE, OPEN, DECIDE.
- IDLE:
  - busy=0.
  - btn_* are ignored.
  - start=1 -> OPEN; on the same edge voted<=0, vote_val<=0, timer<=0, timeout_flag<=0. result keeps its old value.
- OPEN:
  - busy=1; start is ignored.
  - For each voter i with voted[i]=0:
    - btn_da[i]=1 and btn_nu[i]=0 -> voted[i]<=1, vote_val[i]<=1.
    - btn_nu[i]=1 and btn_da[i]=0 -> voted[i]<=1, vote_val[i]<=0.
    - Both buttons high in the same cycle -> invalid, nothing latched, the voter may retry.
  - Once voted[i]=1, further presses by voter i are ignored (no vote change).
  - Let all_next = voted OR newly latched bits in this cycle.
    - all_next = 3'b111 -> DECIDE, timeout_flag stays 0.
    - Else if timer == TIMEOUT_CYCLES-1 -> DECIDE and timeout_flag<=1. Votes valid in this same cycle are still latched; unvoted voters keep vote_val=0 (NO).
    - Else timer <= timer+1.
  - Timer never wraps; it saturates implicitly because OPEN is left at TIMEOUT_CYCLES-1.
- DECIDE (exactly one cycle):
  - busy=1.
  - result <= (v0&v1)|(v0&v2)|(v1&v2) computed over vote_val.
  - result_valid <= 1 for this edge only.
  - -> IDLE.
- Latency: the edge that latches the final vote moves the FSM to DECIDE. result and result_valid are visible after the next edge, i.e. 2 edges after the last press is sampled.
- Earliest session: start at edge 0 and all three votes at edge 1 give result_valid high after edge 2.
- Longest session: no votes at all. The window spans TIMEOUT_CYCLES cycles; result_valid is high after edge TIMEOUT_CYCLES+1 counted from the start edge, with result=0 and timeout_flag=1.
- result_valid is combinationally independent of inputs (registered) and high for exactly one clock per session.
- start held high continuously begins a new session on the first IDLE cycle after DECIDE. Back-to-back sessions are allowed, with one IDLE cycle between them.

Test Plan:
- Reset mid-session: start, voter0 YES, then rst_n=0 for 1 cycle -> all outputs 0, state IDLE, no result_valid pulse; later presses are ignored until start.
- Normal majority: start, then btn_da=3'b011 in the same cycle, then btn_nu=3'b100 -> voted=111, vote_val=011; result=1 with result_valid pulse 2 edges after the NO press; timeout_flag=0.
- Re-vote and conflict: voter1 YES then NO later -> vote_val[1] stays 1. Voter2 with btn_da=btn_nu=1 for 1 cycle -> voted[2]=0; voter2 NO next cycle -> voted[2]=1, vote_val[2]=0.
- Timeout, TIMEOUT_CYCLES=16: only voter0 YES -> OPEN lasts 16 cycles; result=0, timeout_flag=1, vote_val=001, voted=001.
- Vote on last window cycle: voters 0 and 1 YES early, voter2 YES exactly at timer=15 -> accepted; timeout_flag=0, result=1, vote_val=111.
- Ignored inputs: presses in IDLE, and start pulses during OPEN/DECIDE -> no state change. Previous result and timeout_flag are retained until the next accepted start (timeout_flag then clears, result unchanged until the next DECIDE).

Source files
------------

// File: rtl/vot3_sesiune_if.sv
// Ballot session bus: voter buttons and start in, settled votes and decision out.
interface vot3_sesiune_if;
    localparam int unsigned N_VOTERS = 3;

    logic                start;
    logic [N_VOTERS-1:0] btn_da;
    logic [N_VOTERS-1:0] btn_nu;
    logic                busy;
    logic [N_VOTERS-1:0] voted;
    logic [N_VOTERS-1:0] vote_val;
    logic                result;
    logic                result_valid;
    logic                timeout_flag;

    modport master (
        output start, btn_da, btn_nu,
        input  busy, voted, vote_val, result, result_valid, timeout_flag
    );

    modport slave (
        input  start, btn_da, btn_nu,
        output busy, voted, vote_val, result, result_valid, timeout_flag
    );
endinterface

// File: rtl/vot3_sesiune.sv
// Three-voter ballot controller: opens a timed window, latches first valid
// press per voter, forces missing votes to NO and publishes the 2-of-3 majority.
module vot3_sesiune #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    vot3_sesiune_if.slave  bus
);
    localparam int unsigned N_VOTERS = 3;
    localparam int unsigned LAST_CNT = TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        DECIDE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [N_VOTERS-1:0] vote_val_q, vote_val_d;
    logic                busy_q, busy_d;
    logic                result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                timeout_flag_q, timeout_flag_d;

    logic [N_VOTERS-1:0] new_yes_c;
    logic [N_VOTERS-1:0] new_no_c;

    // A press counts only for a voter still pending and only if exactly one button is high.
    assign new_yes_c = ~voted_q & bus.btn_da & ~bus.btn_nu;
    assign new_no_c  = ~voted_q & bus.btn_nu & ~bus.btn_da;

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        voted_d        = voted_q;
        vote_val_d     = vote_val_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_flag_d = timeout_flag_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d        = OPEN;
                    voted_d        = '0;
                    vote_val_d     = '0;
                    timer_d        = '0;
                    timeout_flag_d = 1'b0;
                end
            end
            OPEN: begin
                voted_d    = voted_q | new_yes_c | new_no_c;
                vote_val_d = vote_val_q | new_yes_c;
                if (voted_d == {N_VOTERS{1'b1}}) begin
                    state_d = DECIDE;
                end else if (timer_q == CNT_W'(LAST_CNT)) begin
                    state_d        = DECIDE;
                    timeout_flag_d = 1'b1;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            DECIDE: begin
                result_d       = (vote_val_q[0] & vote_val_q[1]) |
                                 (vote_val_q[0] & vote_val_q[2]) |
                                 (vote_val_q[1] & vote_val_q[2]);
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            voted_q        <= '0;
            vote_val_q     <= '0;
            busy_q         <= 1'b0;
            result_q       <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            voted_q        <= voted_d;
            vote_val_q     <= vote_val_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.voted        = voted_q;
    assign bus.vote_val     = vote_val_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_vot3_sesiune.sv
// Directed bench for vot3_sesiune: reset, majority, re-vote, conflict, timeout,
// last-cycle vote, ignored inputs and back-to-back sessions.
module tb_vot3_sesiune;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    vot3_sesiune_if bus ();

    vot3_sesiune #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic e_busy, input logic [2:0] e_voted,
                       input logic [2:0] e_val, input logic e_res, input logic e_rv,
                       input logic e_tf);
        n_cmp = n_cmp + 6;
        assert (bus.busy === e_busy) else begin
            n_bad++; $error("FAIL %s busy obs=%b exp=%b", tag, bus.busy, e_busy);
        end
        assert (bus.voted === e_voted) else begin
            n_bad++; $error("FAIL %s voted obs=%b exp=%b", tag, bus.voted, e_voted);
        end
        assert (bus.vote_val === e_val) else begin
            n_bad++; $error("FAIL %s vote_val obs=%b exp=%b", tag, bus.vote_val, e_val);
        end
        assert (bus.result === e_res) else begin
            n_bad++; $error("FAIL %s result obs=%b exp=%b", tag, bus.result, e_res);
        end
        assert (bus.result_valid === e_rv) else begin
            n_bad++; $error("FAIL %s result_valid obs=%b exp=%b", tag, bus.result_valid, e_rv);
        end
        assert (bus.timeout_flag === e_tf) else begin
            n_bad++; $error("FAIL %s timeout_flag obs=%b exp=%b", tag, bus.timeout_flag, e_tf);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.btn_da = 3'b000;
        bus.btn_nu = 3'b000;
        tick();
        tick();
        chk("reset", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a session
        rst_n = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.btn_da = 3'b001;
        tick();
        chk("rst_mid_pre", 1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0);
        bus.btn_da = 3'b000; rst_n = 1'b0;
        tick();
        chk("rst_mid_clr", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1; bus.btn_da = 3'b111;
        tick();
        chk("rst_mid_ign1", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst_mid_ign2", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        bus.btn_da = 3'b000;

        // Normal majority: YES,YES then NO
        bus.start = 1'b1;
        tick();
        chk("maj_open", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0; bus.btn_da = 3'b011;
        tick();
        chk("maj_yes", 1'b1, 3'b011, 3'b011, 1'b0, 1'b0, 1'b0);
        bus.btn_da = 3'b000; bus.btn_nu = 3'b100;
        tick();
        chk("maj_decide", 1'b1, 3'b111, 3'b011, 1'b0, 1'b0, 1'b0);
        bus.btn_nu = 3'b000;
        tick();
        chk("maj_result", 1'b0, 3'b111, 3'b011, 1'b1, 1'b1, 1'b0);
        tick();
        chk("maj_pulse_end", 1'b0, 3'b111, 3'b011, 1'b1, 1'b0, 1'b0);

        // Re-vote ignored, conflicting press rejected then retried
        bus.start = 1'b1;
        tick();
        chk("rev_open", 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0; bus.btn_da = 3'b010;
        tick();
        bus.btn_da = 3'b000; bus.btn_nu = 3'b010;
        tick();
        chk("rev_keep", 1'b1, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0);
        bus.btn_da = 3'b100; bus.btn_nu = 3'b100;
        tick();
        chk("rev_conflict", 1'b1, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0);
        bus.btn_da = 3'b000; bus.btn_nu = 3'b100;
        tick();
        chk("rev_retry", 1'b1, 3'b110, 3'b010, 1'b1, 1'b0, 1'b0);
        bus.btn_nu = 3'b001;
        tick();
        chk("rev_decide", 1'b1, 3'b111, 3'b010, 1'b1, 1'b0, 1'b0);
        bus.btn_nu = 3'b000;
        tick();
        chk("rev_result", 1'b0, 3'b111, 3'b010, 1'b0, 1'b1, 1'b0);

        // Timeout with only voter0 YES
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.btn_da = 3'b001;
        tick();
        bus.btn_da = 3'b000;
        for (int i = 2; i <= 15; i++) tick();
        chk("to_edge15", 1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0);
        tick();
        chk("to_edge16", 1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 1'b1);
        tick();
        chk("to_result", 1'b0, 3'b001, 3'b001, 1'b0, 1'b1, 1'b1);

        // Presses in IDLE are ignored; flags retained
        bus.btn_da = 3'b111;
        tick();
        chk("idle_ign", 1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 1'b1);
        bus.btn_da = 3'b000;

        // Vote accepted on the last window cycle; start pulses in OPEN/DECIDE ignored
        bus.start = 1'b1;
        tick();
        chk("last_open", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        bus.btn_da = 3'b011;
        tick();
        bus.btn_da = 3'b000;
        for (int i = 2; i <= 15; i++) tick();
        chk("last_edge15", 1'b1, 3'b011, 3'b011, 1'b0, 1'b0, 1'b0);
        bus.btn_da = 3'b100; bus.start = 1'b0;
        tick();
        chk("last_decide", 1'b1, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0);
        bus.btn_da = 3'b000; bus.start = 1'b1;
        tick();
        chk("last_result", 1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        chk("last_idle", 1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);

        // Back-to-back sessions with start held high
        bus.start = 1'b1;
        tick();
        bus.btn_da = 3'b111;
        tick();
        chk("b2b_decide", 1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
        bus.btn_da = 3'b000;
        tick();
        chk("b2b_res1", 1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 1'b0);
        tick();
        chk("b2b_open2", 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0; bus.btn_nu = 3'b111;
        tick();
        bus.btn_nu = 3'b000;
        tick();
        chk("b2b_res2", 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
